ftsd_scan_ctrl: RTL and testbench

Scan controller for the four-digit 14-segment display path. It generates the 2-bit digit-select that steps the display scan multiplexer and holds the four 4-bit digit values that the multiplexer presents. It accepts new 16-bit display words over a valid/ready handshake and applies them only at frame boundaries, so a word never tears across a scan frame. Optional inter-digit blanking suppresses ghosting. It sits between the application logic and the scan mux/decoder in the display top level.

---
 rtl/ftsd_pkg.sv | 23 ++
 rtl/ftsd_dwell_timer.sv | 40 ++++
 rtl/ftsd_scan_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ftsd_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftsd_pkg.sv
// ---------------------------------------------------------------------------
// ftsd_pkg
// Shared definitions for the four-digit 14-segment display scan path.
//   ftsd_state_e     : scan controller state (IDLE, SHOW, BLANK)
//   FTSD_DIGIT_W     : bits per displayed digit value
//   FTSD_NUM_DIGITS  : number of digits scanned per frame
//   FTSD_SEL_W       : width of the digit-select bus
//   FTSD_WORD_W      : width of a packed display word {d3,d2,d1,d0}
// ---------------------------------------------------------------------------
package ftsd_pkg;

  localparam int unsigned FTSD_DIGIT_W    = 4;
  localparam int unsigned FTSD_NUM_DIGITS = 4;
  localparam int unsigned FTSD_SEL_W      = 2;
  localparam int unsigned FTSD_WORD_W     = FTSD_DIGIT_W * FTSD_NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } ftsd_state_e;

endpackage

// File: rtl/ftsd_dwell_timer.sv
// ---------------------------------------------------------------------------
// ftsd_dwell_timer
// Loadable down-counter that times one scan phase (digit dwell or
// inter-digit blank). Loading value N-1 makes o_done assert in the N-th
// cycle of the phase; the counter stops at zero and never wraps.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset (counter clears to 0)
//   i_en       : phase is running; counts down and qualifies o_done
//   i_load     : load i_load_val (takes priority over counting)
//   i_load_val : phase length minus one
//   o_done     : last cycle of the current phase
// ---------------------------------------------------------------------------
module ftsd_dwell_timer #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Counter holds at zero so a phase that is not acted upon cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/ftsd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ftsd_scan_ctrl
// Scan controller for the four-digit 14-segment display. Steps the 2-bit
// digit select, holds the four displayed digit values and accepts new
// display words over valid/ready. Words accepted while scanning wait in a
// one-entry pending slot and are applied only at the frame boundary (select
// wrapping 3->0), so a word never tears across a frame.
//
// Build option:
//   FTSD_BLANK_EN defined   : a BLANK phase of BLANK_CYCLES separates digits;
//                             the select advances at the start of the blank.
//   FTSD_BLANK_EN undefined : digits follow each other directly (SHOW->SHOW);
//                             ftsd_blank is high only in IDLE.
//
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   scan_en     : 1 = scan runs, 0 = idle and blanked
//   upd_valid   : new display word offered
//   upd_data    : {d3,d2,d1,d0}, d0 in [3:0]
//   upd_ready   : pending slot empty (registered)
//   ftsd_ctl_en : digit select to the scan mux
//   dig0..dig3  : displayed digit values for mux inputs 0..3
//   ftsd_blank  : 1 = top level forces all digit enables off
//   frame_tick  : one-cycle pulse on each 3->0 select wrap
// ---------------------------------------------------------------------------
module ftsd_scan_ctrl
  import ftsd_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_en,
  input  logic                    upd_valid,
  input  logic [FTSD_WORD_W-1:0]  upd_data,
  output logic                    upd_ready,
  output logic [FTSD_SEL_W-1:0]   ftsd_ctl_en,
  output logic [FTSD_DIGIT_W-1:0] dig0,
  output logic [FTSD_DIGIT_W-1:0] dig1,
  output logic [FTSD_DIGIT_W-1:0] dig2,
  output logic [FTSD_DIGIT_W-1:0] dig3,
  output logic                    ftsd_blank,
  output logic                    frame_tick
);

`ifdef FTSD_BLANK_EN
  localparam bit LP_BLANK_ON = 1'b1;
`else
  localparam bit LP_BLANK_ON = 1'b0;
`endif

  // Timer loads are length-1 so o_done lands on the last cycle of a phase.
  localparam logic [CNT_W-1:0] LP_DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

  ftsd_state_e            r_state;
  ftsd_state_e            w_next_state;
  logic [FTSD_SEL_W-1:0]  r_sel;
  logic                   r_blank;
  logic                   r_tick;
  logic                   r_upd_ready;
  logic [FTSD_WORD_W-1:0] r_pend;
  logic [FTSD_WORD_W-1:0] r_word;

  logic                   w_load;
  logic [CNT_W-1:0]       w_load_val;
  logic                   w_done;
  logic                   w_step;
  logic                   w_boundary;
  logic                   w_to_idle;
  logic                   w_accept;

  ftsd_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (r_state != ST_IDLE),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // Next-state logic. Every state change reloads the timer; leaving for
  // IDLE loads zero so the counter is cleared while idle. w_step marks the
  // end of a dwell, where the select advances.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_step       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (scan_en) begin
          w_next_state = ST_SHOW;
          w_load       = 1'b1;
          w_load_val   = LP_DWELL_LOAD;
        end
      end
      ST_SHOW: begin
        if (!scan_en) begin
          w_next_state = ST_IDLE;
          w_load       = 1'b1;
        end else if (w_done) begin
          w_step = 1'b1;
          w_load = 1'b1;
          if (LP_BLANK_ON) begin
            w_next_state = ST_BLANK;
            w_load_val   = LP_BLANK_LOAD;
          end else begin
            w_load_val   = LP_DWELL_LOAD;
          end
        end
      end
`ifdef FTSD_BLANK_EN
      ST_BLANK: begin
        if (!scan_en) begin
          w_next_state = ST_IDLE;
          w_load       = 1'b1;
        end else if (w_done) begin
          w_next_state = ST_SHOW;
          w_load       = 1'b1;
          w_load_val   = LP_DWELL_LOAD;
        end
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
        w_load       = 1'b1;
      end
    endcase
  end

  assign w_boundary = w_step && (r_sel == '1);
  assign w_to_idle  = (r_state != ST_IDLE) && !scan_en;
  assign w_accept   = upd_valid && r_upd_ready;

  // State, select and status outputs. ftsd_blank is derived from the next
  // state so it is registered yet aligned with the state it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_blank <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_blank <= (w_next_state != ST_SHOW);
      r_tick  <= w_boundary;
      if (w_next_state == ST_IDLE) begin
        r_sel <= '0;
      end else if (w_step) begin
        r_sel <= r_sel + FTSD_SEL_W'(1);
      end
    end
  end

  // Pending slot and displayed word. An accept needs an empty slot, so it
  // can never coincide with draining the slot. A word accepted on the very
  // edge that enters IDLE is shown directly, as nothing drains the slot
  // while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_ready <= 1'b1;
      r_pend      <= '0;
      r_word      <= '0;
    end else if (w_accept) begin
      if ((r_state == ST_IDLE) || w_to_idle) begin
        r_word <= upd_data;
      end else begin
        r_pend      <= upd_data;
        r_upd_ready <= 1'b0;
      end
    end else if (!r_upd_ready && (w_boundary || w_to_idle)) begin
      r_word      <= r_pend;
      r_upd_ready <= 1'b1;
    end
  end

  assign upd_ready   = r_upd_ready;
  assign ftsd_ctl_en = r_sel;
  assign ftsd_blank  = r_blank;
  assign frame_tick  = r_tick;
  assign dig0        = r_word[0*FTSD_DIGIT_W +: FTSD_DIGIT_W];
  assign dig1        = r_word[1*FTSD_DIGIT_W +: FTSD_DIGIT_W];
  assign dig2        = r_word[2*FTSD_DIGIT_W +: FTSD_DIGIT_W];
  assign dig3        = r_word[3*FTSD_DIGIT_W +: FTSD_DIGIT_W];

endmodule

// File: tb/tb_ftsd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ftsd_scan_ctrl
// Scoreboard bench for ftsd_scan_ctrl with DWELL_CYCLES=4, BLANK_CYCLES=2.
// The reference model tracks only "cycles since scanning started" plus the
// display word, the pending word and the ready flag; select, blank and tick
// are computed arithmetically from that cycle count. Honours FTSD_BLANK_EN.
// ---------------------------------------------------------------------------
module tb_ftsd_scan_ctrl;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
`ifdef FTSD_BLANK_EN
  localparam int BLK_EFF = BLANK;
`else
  localparam int BLK_EFF = 0;
`endif
  localparam int SLOT  = DWELL + BLK_EFF;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [1:0]  sel;
    logic        blank;
    logic        tick;
    logic        ready;
    logic [15:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = '0;
  logic        upd_ready;
  logic [1:0]  ftsd_ctl_en;
  logic [3:0]  dig0, dig1, dig2, dig3;
  logic        ftsd_blank;
  logic        frame_tick;

  exp_t expQ[$];
  bit   armed = 1'b0;
  int   nChecks = 0;
  int   nPass = 0;

  bit          mActive;
  int          mT;
  logic [15:0] mWord;
  logic [15:0] mPend;
  bit          mReady;

  ftsd_scan_ctrl #(
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK),
    .CNT_W        (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .upd_valid   (upd_valid),
    .upd_data    (upd_data),
    .upd_ready   (upd_ready),
    .ftsd_ctl_en (ftsd_ctl_en),
    .dig0        (dig0),
    .dig1        (dig1),
    .dig2        (dig2),
    .dig3        (dig3),
    .ftsd_blank  (ftsd_blank),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position in the scan is pure arithmetic on mT.
  function automatic logic [1:0] modelSel();
    int slot;
    int off;
    if (!mActive) return 2'd0;
    slot = mT / SLOT;
    off  = mT % SLOT;
    if (off < DWELL) return 2'(slot % 4);
    return 2'((slot + 1) % 4);
  endfunction

  function automatic bit modelBlank();
    return !mActive || ((mT % SLOT) >= DWELL);
  endfunction

  function automatic bit tickAt(input int t);
    return (t > 0) && ((t % FRAME) == ((FRAME - BLK_EFF) % FRAME));
  endfunction

  function automatic void modelReset();
    mActive = 1'b0;
    mT      = 0;
    mWord   = '0;
    mPend   = '0;
    mReady  = 1'b1;
  endfunction

  function automatic void modelStep(input bit en, input bit vld, input logic [15:0] data);
    bit acc;
    bit wasIdle;
    bit toIdle;
    bit bnd;
    acc     = vld && mReady;
    wasIdle = !mActive;
    toIdle  = mActive && !en;
    if (!en) begin
      mActive = 1'b0;
      mT      = 0;
    end else if (!mActive) begin
      mActive = 1'b1;
      mT      = 0;
    end else begin
      mT = mT + 1;
    end
    bnd = mActive && tickAt(mT);
    if (acc) begin
      if (wasIdle || toIdle) mWord = data;
      else begin
        mPend  = data;
        mReady = 1'b0;
      end
    end else if (!mReady && (bnd || toIdle)) begin
      mWord  = mPend;
      mReady = 1'b1;
    end
  endfunction

  function automatic void pushExpected();
    exp_t e;
    e.sel   = modelSel();
    e.blank = modelBlank();
    e.tick  = mActive && tickAt(mT);
    e.ready = mReady;
    e.word  = mWord;
    expQ.push_back(e);
  endfunction

  task automatic checkOne(input string name, input logic [15:0] act, input logic [15:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
  endtask

  task automatic checkOutput(input exp_t e);
    checkOne("ftsd_ctl_en", 16'(ftsd_ctl_en), 16'(e.sel));
    checkOne("ftsd_blank", 16'(ftsd_blank), 16'(e.blank));
    checkOne("frame_tick", 16'(frame_tick), 16'(e.tick));
    checkOne("upd_ready", 16'(upd_ready), 16'(e.ready));
    checkOne("dig3..dig0", {dig3, dig2, dig1, dig0}, e.word);
  endtask

  // Monitor: every clock edge (and every asynchronous reset assertion)
  // presents a new output set, compared against the oldest expectation.
  initial begin
    exp_t e;
    wait (armed);
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (expQ.size() == 0) begin
        nChecks++;
        $display("[TB] FAIL scoreboard_underflow at %0t: got empty queue, expected an entry", $time);
      end else begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic applyStimulus(input bit en, input bit vld, input logic [15:0] data);
    @(negedge clk);
    rst_n     = 1'b1;
    scan_en   = en;
    upd_valid = vld;
    upd_data  = data;
    modelStep(en, vld, data);
    pushExpected();
  endtask

  // Reset lands between edges so the monitor sees the asynchronous effect.
  task automatic applyAsyncReset();
    @(negedge clk);
    #2;
    modelReset();
    pushExpected();
    pushExpected();
    upd_valid = 1'b0;
    rst_n     = 1'b0;
  endtask

  task automatic runCycles(input bit en, input int n);
    repeat (n) applyStimulus(en, 1'b0, 16'h0000);
  endtask

  // Holds valid with stable data until the model says it is taken.
  task automatic offerWord(input bit en, input logic [15:0] data, input int maxCycles);
    bit took;
    took = 1'b0;
    for (int i = 0; i < maxCycles && !took; i++) begin
      took = mReady;
      applyStimulus(en, 1'b1, data);
    end
  endtask

  bit          rndEn;
  bit          rndV;
  logic [15:0] rndD;
  bit          accNow;

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    armed = 1'b1;
    pushExpected();

    $display("[TB] free-running scan");
    runCycles(1'b1, 2 * FRAME + 5);

    $display("[TB] mid-frame updates 4321, AAAA, 5555");
    offerWord(1'b1, 16'h4321, 4 * FRAME);
    offerWord(1'b1, 16'hAAAA, 4 * FRAME);
    offerWord(1'b1, 16'h5555, 4 * FRAME);
    runCycles(1'b1, 2 * FRAME);

    $display("[TB] scan_en drop on digit 2, idle update");
    for (int i = 0; i < 2 * FRAME && !(modelSel() == 2'd2 && !modelBlank()); i++)
      applyStimulus(1'b1, 1'b0, 16'h0000);
    runCycles(1'b0, 3);
    offerWord(1'b0, 16'h0009, 4);
    runCycles(1'b0, 2);
    runCycles(1'b1, FRAME + 3);

    $display("[TB] scan_en drop with full pending slot");
    offerWord(1'b1, 16'h7E57, 4 * FRAME);
    runCycles(1'b0, 3);
    runCycles(1'b1, 7);

    $display("[TB] async reset with full pending slot");
    offerWord(1'b1, 16'hBEEF, 4 * FRAME);
    for (int i = 0; i < SLOT && !(BLK_EFF == 0 || modelBlank()); i++)
      applyStimulus(1'b1, 1'b0, 16'h0000);
    applyAsyncReset();
    runCycles(1'b0, 3);
    runCycles(1'b1, FRAME);

    $display("[TB] randomized traffic");
    rndEn = 1'b1;
    rndV  = 1'b0;
    rndD  = '0;
    for (int c = 0; c < 700; c++) begin
      if (c == 350) begin
        applyAsyncReset();
        rndV = 1'b0;
      end
      if (!rndV && ($urandom_range(0, 3) == 0)) begin
        rndV = 1'b1;
        rndD = 16'($urandom);
      end
      if (rndEn && ($urandom_range(0, 59) == 0)) rndEn = 1'b0;
      else if (!rndEn && ($urandom_range(0, 3) == 0)) rndEn = 1'b1;
      accNow = rndV && mReady;
      applyStimulus(rndEn, rndV, rndD);
      if (accNow) rndV = 1'b0;
    end
    runCycles(1'b1, 4);

    @(posedge clk);
    #2;
    checkOne("scoreboard_drain", 16'(expQ.size()), 16'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
